multi_operand_adder: RTL

- Parametrised sequential multi-operand adder, replacing the fixed five-operand pushbutton adder.
- Up to NUM_OPS operands of WIDTH bits are loaded into an internal operand bank, one per load strobe.
- A start request sums the bank serially, one operand per clock, through a single adder.
- Mode select: fresh sum, or continue from the previous result (running total). Sits between switch/button debounce logic and the LED/display driver.

---
 rtl/multi_operand_adder.sv | 105 ++++++++++
 1 files changed

// File: rtl/multi_operand_adder.sv
// multi_operand_adder
//   Sequential multi-operand adder. Operands are written one at a time into a
//   NUM_OPS-deep bank. A start request then sums the bank serially, one slot
//   per clock, through a single adder. The pass starts either from zero or
//   from the previous {cout,sum} result, which gives a running total.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   load_en/load_idx : write din into slot load_idx (IDLE only; out-of-range dropped)
//   din              : unsigned operand
//   start, mode      : begin a pass (IDLE only); mode=1 continues from {cout,sum}
//   sum, cout        : last completed result, low SUM_W bits and bit SUM_W
//   valid            : one-cycle pulse when sum/cout update
//   busy             : high while a pass is in progress
module multi_operand_adder #(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 5,
    parameter int SUM_W   = 6,
    parameter int IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             mode,
    output logic [SUM_W-1:0] sum,
    output logic             cout,
    output logic             valid,
    output logic             busy
);
    localparam int ACC_W = SUM_W + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                          state;
    logic [NUM_OPS-1:0][WIDTH-1:0]   bank;
    logic [ACC_W-1:0]                acc;
    logic [ACC_W-1:0]                acc_nxt;
    logic [IDX_W-1:0]                idx;
    logic [WIDTH-1:0]                rd;
    logic                            bank_we;

    // Bank is frozen during a pass; a write coinciding with start still
    // lands, and slot 0 is first read one edge later, so it is seen.
    assign bank_we = (state == IDLE) && load_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank <= '0;
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (bank_we && load_idx == IDX_W'(i))
                    bank[i] <= din;
            end
        end
    end

    // Read mux by compare so out-of-range indices simply select nothing.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (idx == IDX_W'(i))
                rd = bank[i];
        end
    end

    assign acc_nxt = acc + ACC_W'(rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                        idx   <= '0;
                        acc   <= mode ? {cout, sum} : '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_nxt;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(NUM_OPS - 1)) begin
                        {cout, sum} <= acc_nxt;
                        valid       <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
